sd_spi_responder: RTL and testbench
===================================

# sd_spi_responder

Synthesizable SD-card SPI-mode responder: the card side of the host initialization link. It samples the host's SCLK, CS and MOSI with the system clock and decodes 48-bit command frames. It checks framing and CRC7, then drives R1 and R7 responses on MISO after a programmable NCR gap. Its purpose is to close the loop with the host init logic in simulation and on FPGA, without a physical card.

## Interface
Parameters:
- NCR_BYTES, 1, number of 0xFF bytes (8·NCR_BYTES MISO bits held high) between the command end bit and the R1 MSB; legal range 1..8.
- CRC_CHECK, 1, 1 = CRC7 mismatch is an error; 0 = CRC7 field ignored.
- INIT_POLLS, 2, number of ACMD41 commands needed before the card leaves the idle state; legal range 1..15.

Ports:
- input_clk  in  1  system clock; must run at ≥ 8× the SCLK frequency.
- resend  in  1  reset; synchronous, active-low.
- SCLK_bit  in  1  SPI clock from host, mode 0, asynchronous to input_clk.
- CS_bit  in  1  chip select from host, active-low, asynchronous.
- MOSI_bit  in  1  host data, asynchronous.
- MISO_bit  out  1  card data to host.
- MISO_oe  out  1  high while the synchronized CS is low.
- cmd_valid  out  1  one-cycle pulse when a frame has been decoded (including error frames).
- cmd_index  out  6  index of the last decoded frame.
- cmd_arg  out  32  argument of the last decoded frame.
- crc_err  out  1  error flag of the last decoded frame.
- in_idle  out  1  R1 idle bit currently reported by the card.
- spi_mode  out  1  set by the first valid CMD0.

## Operation
- SCLK, CS and MOSI each pass through a 2-FF synchronizer. A third register on SCLK provides edge detection.
  - An SCLK rising edge samples MOSI.
  - An SCLK falling edge advances MISO.
- A synchronized CS high forces the state to IDLE from any state. It also forces MISO_bit=1 and MISO_oe=0. A CS high always wins over an SCLK edge seen in the same cycle.
- States:
  - IDLE: on a rising edge with MOSI=0, load the start bit and go to RECV.
  - RECV: shift 47 more bits into a 48-bit register. After the 48th bit, go to CHECK.
  - CHECK: one input_clk cycle (see the decode rules below). Go to WAIT_NCR, or go to IDLE if no response is owed.
  - WAIT_NCR: hold MISO=1 for 8·NCR_BYTES falling edges, then go to SEND_R1.
  - SEND_R1: shift out 8 bits, MSB first, one per falling edge. For CMD8 go to SEND_R7, otherwise go to IDLE.
  - SEND_R7: shift out 32 bits, then go to IDLE.
- MOSI is ignored outside IDLE and RECV.
- Frame check:
  - Bit 46 (the transmission bit) must be 1.
  - Bit 0 (the end bit) must be 1.
  - With CRC_CHECK=1, bits 7:1 must equal the CRC7 of bits 47:8, using polynomial x^7+x^3+1 with initial value 0.
  - Any failure is an error.
- Decode rules in CHECK; cmd_valid pulses in every case:
  - spi_mode=0 and the frame is not a valid CMD0: no response, nothing changes, return to IDLE.
  - Error frame: R1 = {6'b0, 0, in_idle} | 8'h08 (CRC-error bit). crc_err=1, and the command is not executed.
  - CMD0: spi_mode←1, in_idle←1, app flag cleared, poll counter←INIT_POLLS. R1=0x01.
  - CMD8: R1={7'b0,in_idle}. R7 = {4'h0, 16'h0, arg[11:8], arg[7:0]}.
  - CMD55: app flag←1. R1={7'b0,in_idle}.
  - CMD41 with the app flag set (ACMD41): decrement the poll counter, saturating at 0. When it reaches 0, in_idle←0. R1 = {7'b0, in_idle after update}.
  - Any other index, or CMD41 without the app flag: R1 = {7'b0,in_idle} | 8'h04.
  - The app flag clears on every decoded frame except a valid CMD55.
- The R1 value, R7 value and all state updates are committed in CHECK. A CS abort during WAIT_NCR, SEND_R1 or SEND_R7 truncates the response but does not undo those updates.

## Timing
- Reset values: MISO_bit=1, MISO_oe=0, cmd_valid=0, cmd_index=0, cmd_arg=0, crc_err=0, in_idle=1, spi_mode=0. The poll counter resets to INIT_POLLS, the app flag to 0, and the state to IDLE.
- A reset asserted mid-frame or mid-response takes effect at the next input_clk edge.
- Latency from a pin edge to its internal edge detect is 3 input_clk cycles.
- MISO_bit changes ≤ 4 input_clk cycles after an SCLK falling edge at the pin. It is stable before the next rising edge at any legal SCLK ratio.
- cmd_valid asserts in CHECK, ≤ 4 input_clk cycles after the pin-level rising edge of the end bit. cmd_index, cmd_arg and crc_err update in the same cycle and hold until the next decode.
- NCR counting starts at the first falling edge after the end-bit rising edge. The host therefore samples exactly 8·NCR_BYTES ones before R1[7].
- Back-to-back frames: after the last response bit, the responder is in IDLE. A start bit on the very next rising edge is accepted.

## Test plan
- Reset, then CMD0 0x400000000095 → 8 ones (NCR_BYTES=1), then R1=0x01. spi_mode=1, in_idle=1, cmd_valid pulses once.
- After CMD0, send CMD8 0x48000001AA87 → R1=0x01, then 0x000001AA. cmd_arg=0x000001AA.
- Before any CMD0, send CMD8 → MISO stays 1 for 60 SCLK cycles. After CMD0, send 0x400000000097 (bad CRC) → R1=0x09, crc_err=1.
- After CMD0:
  - CMD55 0x770000000065 → 0x01; ACMD41 0x694000000077 → 0x01.
  - Repeat CMD55 + ACMD41 → 0x00, and in_idle=0.
  - CMD41 without CMD55 → 0x04.
- Raise CS after 20 bits of a frame, lower it again, then send CMD0 → the partial frame is discarded and R1=0x01.
- Raise CS after 3 bits of the R7 payload → MISO=1 and MISO_oe=0 within 3 input_clk cycles. The next CMD8 answers normally.

Source files
------------

// File: rtl/sd_spi_responder_if.sv
// rtl/sd_spi_responder_if.sv - SPI pin bundle between an SD host and the card responder
interface sd_spi_responder_if;
  logic SCLK_bit;
  logic CS_bit;
  logic MOSI_bit;
  logic MISO_bit;
  logic MISO_oe;

  modport master (output SCLK_bit, output CS_bit, output MOSI_bit, input MISO_bit, input MISO_oe);
  modport slave  (input SCLK_bit, input CS_bit, input MOSI_bit, output MISO_bit, output MISO_oe);
endinterface

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SD card SPI-mode responder: frame capture, CRC7 check, R1/R7 replies
module sd_spi_responder #(
  parameter int NCR_BYTES  = 1,
  parameter int CRC_CHECK  = 1,
  parameter int INIT_POLLS = 2
) (
  input  logic              input_clk,
  input  logic              resend,
  sd_spi_responder_if.slave spi,
  output logic              cmd_valid,
  output logic [5:0]        cmd_index,
  output logic [31:0]       cmd_arg,
  output logic              crc_err,
  output logic              in_idle,
  output logic              spi_mode
);
  localparam logic [6:0] NCR_LAST   = 7'(8 * NCR_BYTES - 1);
  localparam logic [3:0] POLLS_INIT = 4'(INIT_POLLS);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CHECK, S_WAIT_NCR, S_SEND_R1, S_SEND_R7} state_t;
  state_t r_state, w_state_nxt;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1, r_cs_s2, r_mosi_s1, r_mosi_s2;
  logic [47:0] r_frame;
  logic [6:0]  r_cnt;
  logic [39:0] r_tx;
  logic        r_miso, r_app, r_has_r7;
  logic [3:0]  r_polls;

  logic        w_cs_hi, w_rise, w_fall;
  logic        w_sample, w_cnt_inc, w_check, w_tx_active;
  logic [5:0]  w_idx;
  logic [31:0] w_arg;
  logic        w_crc_ok, w_frame_ok, w_cmd0_ok, w_respond;
  logic [7:0]  w_r1;
  logic [31:0] w_r7;
  logic        w_has_r7, w_idle_nxt, w_app_nxt, w_mode_nxt;
  logic [3:0]  w_polls_nxt, w_polls_dec;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  always_ff @(posedge input_clk) begin
    if (!resend) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_mosi_s1 <= 1'b1;
      r_mosi_s2 <= 1'b1;
    end else begin
      r_sclk_s1 <= spi.SCLK_bit;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= spi.CS_bit;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= spi.MOSI_bit;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // CS high masks SCLK edges so a deselect always wins over a same-cycle edge
  assign w_cs_hi = r_cs_s2;
  assign w_rise  = r_sclk_s2 & ~r_sclk_s3 & ~w_cs_hi;
  assign w_fall  = ~r_sclk_s2 & r_sclk_s3 & ~w_cs_hi;

  assign w_idx      = r_frame[45:40];
  assign w_arg      = r_frame[39:8];
  assign w_crc_ok   = (CRC_CHECK == 0) || (crc7(r_frame[47:8]) == r_frame[7:1]);
  assign w_frame_ok = ~r_frame[47] & r_frame[46] & r_frame[0] & w_crc_ok;
  assign w_cmd0_ok  = w_frame_ok && (w_idx == 6'd0);
  assign w_respond  = spi_mode | w_cmd0_ok;

  always_comb begin
    w_polls_dec = (r_polls == 4'd0) ? 4'd0 : r_polls - 4'd1;
    w_r1        = {7'b0, in_idle};
    w_r7        = 32'h0;
    w_has_r7    = 1'b0;
    w_idle_nxt  = in_idle;
    w_app_nxt   = 1'b0;
    w_polls_nxt = r_polls;
    w_mode_nxt  = spi_mode;
    if (!w_frame_ok) begin
      w_r1 = {7'b0, in_idle} | 8'h08;
    end else begin
      case (w_idx)
        6'd0: begin
          w_mode_nxt  = 1'b1;
          w_idle_nxt  = 1'b1;
          w_polls_nxt = POLLS_INIT;
          w_r1        = 8'h01;
        end
        6'd8: begin
          w_r7     = {20'h0, w_arg[11:0]};
          w_has_r7 = 1'b1;
        end
        6'd55: w_app_nxt = 1'b1;
        6'd41: begin
          if (r_app) begin
            w_polls_nxt = w_polls_dec;
            if (w_polls_dec == 4'd0) w_idle_nxt = 1'b0;
            w_r1 = {7'b0, w_idle_nxt};
          end else begin
            w_r1 = {7'b0, in_idle} | 8'h04;
          end
        end
        default: w_r1 = {7'b0, in_idle} | 8'h04;
      endcase
    end
  end

  always_ff @(posedge input_clk) begin
    if (!resend) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_hi) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (w_rise && !r_mosi_s2) w_state_nxt = S_RECV;
        S_RECV:     if (w_rise && r_cnt == 7'd46) w_state_nxt = S_CHECK;
        S_CHECK:    w_state_nxt = w_respond ? S_WAIT_NCR : S_IDLE;
        S_WAIT_NCR: if (w_fall && r_cnt == NCR_LAST) w_state_nxt = S_SEND_R1;
        S_SEND_R1:  if (w_fall && r_cnt == 7'd7) w_state_nxt = r_has_r7 ? S_SEND_R7 : S_IDLE;
        S_SEND_R7:  if (w_fall && r_cnt == 7'd31) w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sample    = 1'b0;
    w_cnt_inc   = 1'b0;
    w_check     = 1'b0;
    w_tx_active = 1'b0;
    case (r_state)
      S_IDLE:     w_sample = w_rise & ~r_mosi_s2;
      S_RECV:     begin w_sample = w_rise; w_cnt_inc = w_rise; end
      S_CHECK:    w_check = ~w_cs_hi;
      S_WAIT_NCR: w_cnt_inc = w_fall;
      S_SEND_R1,
      S_SEND_R7:  begin w_cnt_inc = w_fall; w_tx_active = 1'b1; end
      default:    ;
    endcase
  end

  // MISO only moves on falling edges; the last response bit stays up into IDLE
  always_ff @(posedge input_clk) begin
    if (!resend) begin
      r_frame   <= 48'h0;
      r_cnt     <= 7'd0;
      r_tx      <= 40'h0;
      r_miso    <= 1'b1;
      r_has_r7  <= 1'b0;
      r_app     <= 1'b0;
      r_polls   <= POLLS_INIT;
      cmd_valid <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'h0;
      crc_err   <= 1'b0;
      in_idle   <= 1'b1;
      spi_mode  <= 1'b0;
    end else begin
      cmd_valid <= w_check;
      if (w_state_nxt != r_state) r_cnt <= 7'd0;
      else if (w_cnt_inc)         r_cnt <= r_cnt + 7'd1;
      if (w_sample) r_frame <= {r_frame[46:0], r_mosi_s2};
      if (w_cs_hi) begin
        r_miso <= 1'b1;
      end else if (w_fall) begin
        if (w_tx_active) begin
          r_miso <= r_tx[39];
          r_tx   <= {r_tx[38:0], 1'b1};
        end else begin
          r_miso <= 1'b1;
        end
      end
      if (w_check) begin
        cmd_index <= w_idx;
        cmd_arg   <= w_arg;
        crc_err   <= ~w_frame_ok;
        if (w_respond) begin
          r_tx     <= {w_r1, w_r7};
          r_has_r7 <= w_has_r7;
          in_idle  <= w_idle_nxt;
          spi_mode <= w_mode_nxt;
          r_app    <= w_app_nxt;
          r_polls  <= w_polls_nxt;
        end
      end
    end
  end

  assign spi.MISO_bit = r_miso;
  assign spi.MISO_oe  = ~r_cs_s2;
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - scoreboard bench for sd_spi_responder with a behavioural card model
module tb_sd_spi_responder;
  localparam int NCR   = 1;
  localparam int POLLS = 2;
  localparam int HALF  = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, crc_err, in_idle, spi_mode;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  sd_spi_responder_if spi ();

  sd_spi_responder #(.NCR_BYTES(NCR), .CRC_CHECK(1), .INIT_POLLS(POLLS)) dut (
    .input_clk(clk),
    .resend(rstn),
    .spi(spi),
    .cmd_valid(cmd_valid),
    .cmd_index(cmd_index),
    .cmd_arg(cmd_arg),
    .crc_err(crc_err),
    .in_idle(in_idle),
    .spi_mode(spi_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         err;
    logic         idle;
    logic         mode;
    int           nbits;
    logic [127:0] seq;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0, issued = 0, pulses = 0;
  bit   m_mode, m_idle, m_app;
  int   m_polls;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic exp_t predict(input logic [47:0] f);
    exp_t       e;
    bit         ok, resp, r7_on;
    logic [7:0] r1;
    logic [31:0] r7;
    ok    = !f[47] && f[46] && f[0] && (crc7_ref(f[47:8]) == f[7:1]);
    e.idx = f[45:40];
    e.arg = f[39:8];
    e.err = !ok;
    resp  = m_mode || (ok && f[45:40] == 6'd0);
    r7_on = 0;
    r1    = 8'h00;
    r7    = 32'h0;
    if (resp) begin
      if (!ok) begin
        r1 = 8'h08 | 8'(m_idle); m_app = 0;
      end else if (e.idx == 0) begin
        m_mode = 1; m_idle = 1; m_app = 0; m_polls = POLLS; r1 = 8'h01;
      end else if (e.idx == 8) begin
        r1 = 8'(m_idle); r7 = e.arg & 32'hFFF; r7_on = 1; m_app = 0;
      end else if (e.idx == 55) begin
        r1 = 8'(m_idle); m_app = 1;
      end else if (e.idx == 41 && m_app) begin
        if (m_polls > 0) m_polls--;
        if (m_polls == 0) m_idle = 0;
        r1 = 8'(m_idle); m_app = 0;
      end else begin
        r1 = 8'h04 | 8'(m_idle); m_app = 0;
      end
    end
    e.idle = m_idle;
    e.mode = m_mode;
    e.seq  = '1;
    if (resp) begin
      e.seq[127-8*NCR -: 8] = r1;
      if (r7_on) e.seq[119-8*NCR -: 32] = r7;
      e.nbits = 8 * NCR + 8 + (r7_on ? 32 : 0);
    end else begin
      e.nbits = 60;
    end
    return e;
  endfunction

  task automatic clk_bit(input logic b);
    spi.MOSI_bit = b;
    repeat (HALF) @(negedge clk);
    spi.SCLK_bit = 1'b1;
    repeat (HALF) @(negedge clk);
    spi.SCLK_bit = 1'b0;
  endtask

  task automatic issue(input logic [47:0] f, input int trunc);
    exp_t e;
    e = predict(f);
    if (trunc > 0) e.nbits = trunc;
    exp_q.push_back(e);
    issued++;
    for (int i = 47; i >= 0; i--) clk_bit(f[i]);
    for (int i = 0; i < e.nbits; i++) clk_bit(1'b1);
  endtask

  initial begin : monitor
    exp_t         e;
    logic [127:0] got, want;
    forever begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        pulses++;
        chk("expected_item_available", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cmd_index", cmd_index, e.idx);
          chk("cmd_arg", cmd_arg, e.arg);
          chk("crc_err", crc_err, e.err);
          chk("in_idle", in_idle, e.idle);
          chk("spi_mode", spi_mode, e.mode);
          @(negedge clk);
          chk("cmd_valid_single_cycle", cmd_valid, 1'b0);
          got = '0;
          for (int k = 0; k < e.nbits; k++) begin
            @(posedge spi.SCLK_bit);
            got = {got[126:0], spi.MISO_bit};
          end
          want = e.seq >> (128 - e.nbits);
          chk("miso_seq", got, want);
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time budget, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rstn = 1'b0;
    spi.CS_bit = 1'b1;
    spi.SCLK_bit = 1'b0;
    spi.MOSI_bit = 1'b1;
    m_mode = 0; m_idle = 1; m_app = 0; m_polls = POLLS;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_miso", spi.MISO_bit, 1'b1);
    chk("rst_oe", spi.MISO_oe, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_cmd_index", cmd_index, 6'd0);
    chk("rst_cmd_arg", cmd_arg, 32'h0);
    chk("rst_crc_err", crc_err, 1'b0);
    chk("rst_in_idle", in_idle, 1'b1);
    chk("rst_spi_mode", spi_mode, 1'b0);
    spi.CS_bit = 1'b0;
    repeat (4) @(negedge clk);
    chk("oe_after_select", spi.MISO_oe, 1'b1);

    issue(48'h48000001AA87, 0);
    issue(48'h400000000095, 0);
    issue(48'h48000001AA87, 0);
    issue(48'h400000000097, 0);
    issue(48'h770000000065, 0);
    issue(48'h694000000077, 0);
    issue(48'h770000000065, 0);
    issue(48'h694000000077, 0);
    issue(48'h694000000077, 0);

    begin : partial_frame
      logic [47:0] pf;
      pf = 48'h770000000065;
      for (int i = 47; i >= 28; i--) clk_bit(pf[i]);
      spi.CS_bit = 1'b1;
      repeat (10) @(negedge clk);
      spi.CS_bit = 1'b0;
      repeat (4) @(negedge clk);
    end
    issue(48'h400000000095, 0);

    issue(48'h48000001AA87, 8 * NCR + 8 + 3);
    spi.CS_bit = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_miso_high", spi.MISO_bit, 1'b1);
    chk("abort_oe_low", spi.MISO_oe, 1'b0);
    repeat (6) @(negedge clk);
    spi.CS_bit = 1'b0;
    repeat (4) @(negedge clk);
    issue(48'h48000001AA87, 0);

    for (int n = 0; n < 20; n++) begin
      int          sel;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [47:0] f;
      sel = $urandom_range(0, 9);
      arg = $urandom;
      case (sel)
        0:       idx = 6'd0;
        1, 2:    idx = 6'd8;
        3, 4:    idx = 6'd55;
        5, 6:    idx = 6'd41;
        default: idx = 6'($urandom_range(0, 63));
      endcase
      f = make_frame(idx, arg);
      if (sel == 8) f[1] = ~f[1];
      else if (sel == 9) begin
        if ($urandom_range(0, 1) == 1) f[0] = 1'b0;
        else f[46] = 1'b0;
      end
      issue(f, 0);
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("pulse_count", pulses, issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
